aes_out_line_arbiter: RTL and testbench

Round-robin arbiter that shares the 128-to-512-bit output line buffer between several AES core result streams. It grants one requester for an entire 512-bit line (four 128-bit lanes), so every line holds blocks from a single source. When a message ends mid-line, it zero-pads the remaining lanes. A line-metadata FIFO records the source id and a lane keep mask for each completed line and presents them alongside the 512-bit buffer output on a valid/ready master port.

---
 rtl/aes_out_line_arbiter.sv | 158 +++++++++++++++
 tb/tb_aes_out_line_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_line_arbiter.sv
// Round-robin arbiter packing AES result blocks into whole 512-bit lines.
// Each line comes from one source; short messages are zero-padded.
module aes_out_line_arbiter #(
  parameter int N_REQ      = 4,
  parameter int META_DEPTH = 8,
  localparam int SW = $clog2(N_REQ),
  localparam int AW = $clog2(META_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [N_REQ*128-1:0] req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [127:0]         buf_din,
  output logic                 buf_we,
  input  logic                 buf_full,
  input  logic                 buf_empty,
  input  logic [511:0]         buf_dout,
  output logic                 buf_rd_en,
  output logic                 buf_clr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [511:0]         m_data,
  output logic [SW-1:0]        m_src,
  output logic [3:0]           m_keep
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] PAD  = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] sel;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_next;
  logic [SW-1:0] pick;
  logic          found;
  logic [1:0]    lane;
  logic [3:0]    keep;
  logic [3:0]    push_keep;
  logic          beat;
  logic          pad_wr;
  logic          push;
  logic          pop;

  logic [SW+3:0] meta_mem [META_DEPTH];
  logic [SW+3:0] head;
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          meta_empty;
  logic          meta_full;

  // First valid requester at or after rr_ptr, cyclically
  always_comb begin
    int idx;
    idx   = 0;
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
  end

  assign rr_next = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;

  assign meta_empty = (wptr == rptr);
  assign meta_full  = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);

  assign beat   = (state == FILL) && !flush && !buf_full && req_valid[sel];
  assign pad_wr = (state == PAD) && !flush && !buf_full;
  assign push   = (beat || pad_wr) && (lane == 2'd3);
  assign push_keep = beat ? (keep | 4'b1000) : keep;

  always_comb begin
    req_ready = '0;
    if ((state == FILL) && !flush && !buf_full)
      req_ready[sel] = 1'b1;
  end

  assign buf_we  = beat || pad_wr;
  assign buf_din = beat ? req_data[int'(sel)*128 +: 128] : '0;
  assign buf_clr = flush;

  assign m_valid   = !buf_empty && !meta_empty;
  assign pop       = m_valid && m_ready && !flush;
  assign buf_rd_en = pop;
  assign m_data    = buf_dout;

  assign head   = meta_mem[rptr[AW-1:0]];
  assign m_src  = meta_empty ? '0 : head[SW+3:4];
  assign m_keep = meta_empty ? '0 : head[3:0];

  always_ff @(posedge clk) begin
    if (push && !flush)
      meta_mem[wptr[AW-1:0]] <= {sel, push_keep};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
      lane   <= '0;
      keep   <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else if (flush) begin
      state <= IDLE;
      lane  <= '0;
      keep  <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case (state)
        IDLE: begin
          if (!meta_full && found) begin
            sel   <= pick;
            lane  <= '0;
            keep  <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (beat) begin
            keep[lane] <= 1'b1;
            lane       <= lane + 2'd1;
            if (lane == 2'd3) begin
              state  <= IDLE;
              rr_ptr <= rr_next;
            end else if (req_last[sel]) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          if (pad_wr) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              state  <= IDLE;
              rr_ptr <= rr_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_out_line_arbiter.sv
// Bench for aes_out_line_arbiter: line buffer model, requester queues,
// per-source expected lines and a decoupled output monitor.
module tb_aes_out_line_arbiter;

  localparam int N   = 4;
  localparam int D   = 8;
  localparam int SW  = 2;
  localparam int CAP = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*128-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [127:0]   buf_din;
  logic           buf_we;
  logic           buf_full;
  logic           buf_empty;
  logic [511:0]   buf_dout = '0;
  logic           buf_rd_en;
  logic           buf_clr;
  logic           m_valid;
  logic           m_ready;
  logic [511:0]   m_data;
  logic [SW-1:0]  m_src;
  logic [3:0]     m_keep;

  always #5 clk = ~clk;

  aes_out_line_arbiter #(.N_REQ(N), .META_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .buf_din(buf_din), .buf_we(buf_we),
    .buf_full(buf_full), .buf_empty(buf_empty),
    .buf_dout(buf_dout), .buf_rd_en(buf_rd_en),
    .buf_clr(buf_clr), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data),
    .m_src(m_src), .m_keep(m_keep)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] rq_data [N][$];
  bit           rq_last [N][$];
  logic [511:0] exp_line [N][$];
  logic [3:0]   exp_keep [N][$];
  int           exp_src [$];
  bit           chk_order = 1'b0;

  logic [511:0] bq [$];
  logic [511:0] acc = '0;
  int           pcnt = 0;
  logic         full_r = 1'b0;
  logic         empty_r = 1'b1;
  logic         force_full;
  logic [N-1:0] en;
  int           cyc = 0;
  int           wr_cnt = 0;
  int           zero_wr = 0;
  int           pop_cnt = 0;
  int           clr_cnt = 0;
  int           done_cyc [$];

  assign buf_full  = force_full | full_r;
  assign buf_empty = empty_r;

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Line buffer model plus requester-side consumption
  always @(posedge clk) begin
    cyc++;
    if (rst || buf_clr) begin
      bq.delete();
      acc  = '0;
      pcnt = 0;
    end else begin
      if (buf_rd_en && bq.size() > 0) void'(bq.pop_front());
      if (buf_we) begin
        acc[pcnt*128 +: 128] = buf_din;
        wr_cnt++;
        if (buf_din == '0) zero_wr++;
        pcnt++;
        if (pcnt == 4) begin
          bq.push_back(acc);
          done_cyc.push_back(cyc);
          acc  = '0;
          pcnt = 0;
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i] && rq_data[i].size() > 0) begin
          void'(rq_data[i].pop_front());
          void'(rq_last[i].pop_front());
        end
    end
    full_r   <= (bq.size() >= CAP);
    empty_r  <= (bq.size() == 0);
    buf_dout <= (bq.size() > 0) ? bq[0] : '0;
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (en[i] && rq_data[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = rq_last[i][0];
        req_data[i*128 +: 128] = rq_data[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (buf_clr) clr_cnt++;
    if (!rst && !flush && m_valid && m_ready) begin
      pop_cnt++;
      if (exp_line[m_src].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_line src=%0d", m_src);
      end else begin
        chk("line_data", m_data, exp_line[m_src].pop_front());
        chk("line_keep", {508'd0, m_keep}, {508'd0, exp_keep[m_src].pop_front()});
      end
      if (chk_order) begin
        if (exp_src.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rr_extra got=%0d", m_src);
        end else begin
          chk("rr_src", {510'd0, m_src}, 512'(exp_src.pop_front()));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enq(input int s, input int n, input bit seq);
    logic [511:0] ln;
    logic [127:0] d;
    int c;
    ln = '0;
    c  = 0;
    for (int k = 0; k < n; k++) begin
      d = seq ? 128'(k + 1)
              : ({$urandom, $urandom, $urandom, $urandom} | 128'd1);
      rq_data[s].push_back(d);
      rq_last[s].push_back(k == n - 1);
      ln[c*128 +: 128] = d;
      c++;
      if (c == 4 || k == n - 1) begin
        exp_line[s].push_back(ln);
        exp_keep[s].push_back(4'((1 << c) - 1));
        ln = '0;
        c  = 0;
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
      exp_line[i].delete();
      exp_keep[i].delete();
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < N; i++)
      if (rq_data[i].size() != 0 || exp_line[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step(1);
      n++;
    end
    step(3);
    chk(nm, 512'(all_idle()), 512'd1);
  endtask

  task automatic wait_wr(input string nm, input int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 100) begin
      step(1);
      n++;
    end
    chk(nm, 512'(wr_cnt), 512'(target));
  endtask

  int base;
  int nl;

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    force_full = 1'b0; en = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl", 512'({req_ready, buf_we, buf_rd_en, buf_clr, m_valid}), 512'd0);
    chk("rst_din", 512'(buf_din), 512'd0);
    chk("rst_meta", 512'({m_src, m_keep}), 512'd0);

    // Single full line, sequential data
    step(1);
    m_ready = 1'b1;
    enq(0, 4, 1'b1);
    base = pop_cnt;
    en = 4'b0001;
    wait_idle("idle_single", 100);
    chk("single_pops", 512'(pop_cnt - base), 512'd1);

    // Full-rate cadence over three lines
    done_cyc.delete();
    enq(0, 12, 1'b0);
    wait_idle("idle_cadence", 200);
    chk("cadence_lines", 512'(done_cyc.size()), 512'd3);
    if (done_cyc.size() == 3) begin
      chk("cadence_1", 512'(done_cyc[1] - done_cyc[0]), 512'd5);
      chk("cadence_2", 512'(done_cyc[2] - done_cyc[1]), 512'd5);
    end

    // Short message from requester 2, padded
    zero_wr = 0;
    en = 4'b0100;
    enq(2, 2, 1'b0);
    wait_idle("idle_pad", 100);
    chk("pad_writes", 512'(zero_wr), 512'd2);

    // Round robin from a fresh reset
    en = '0;
    step(1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp_src.push_back(i);
    for (int i = 0; i < N; i++) enq(i, 8, 1'b0);
    chk_order = 1'b1;
    en = 4'b1111;
    wait_idle("idle_rr", 400);
    chk_order = 1'b0;
    chk("rr_left", 512'(exp_src.size()), 512'd0);

    // Buffer-full stall after lane 1
    en = 4'b0001;
    base = wr_cnt;
    enq(0, 4, 1'b0);
    wait_wr("stall_reach", base + 2);
    force_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", 512'(req_ready), 512'd0);
      chk("stall_we", 512'(buf_we), 512'd0);
    end
    step(1);
    chk("stall_hold", 512'(wr_cnt), 512'(base + 2));
    force_full = 1'b0;
    wait_idle("idle_stall", 100);

    // Metadata FIFO full
    m_ready = 1'b0;
    nl = done_cyc.size();
    en = 4'b0010;
    enq(1, 40, 1'b0);
    for (int k = 0; k < 200 && bq.size() < D; k++) step(1);
    step(10);
    chk("meta_full_lines", 512'(bq.size()), 512'(D));
    @(negedge clk);
    chk("meta_full_ready", 512'({req_ready, buf_we}), 512'd0);
    step(1);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    step(20);
    chk("meta_one_more", 512'(done_cyc.size() - nl), 512'(D + 1));
    chk("meta_level", 512'(bq.size()), 512'(D));
    m_ready = 1'b1;
    wait_idle("idle_meta", 400);

    // Flush mid-line with one completed line held
    m_ready = 1'b0;
    en = 4'b1000;
    enq(3, 4, 1'b0);
    for (int k = 0; k < 50 && bq.size() < 1; k++) step(1);
    @(negedge clk);
    chk("flush_pre_valid", 512'(m_valid), 512'd1);
    step(1);
    en = 4'b0010;
    base = wr_cnt;
    enq(1, 4, 1'b0);
    wait_wr("flush_reach", base + 2);
    clr_cnt = 0;
    flush = 1'b1;
    en = '0;
    clear_all();
    @(negedge clk);
    chk("flush_cycle", 512'({req_ready, buf_we, buf_rd_en}), 512'd0);
    step(1);
    flush = 1'b0;
    step(3);
    chk("flush_clr_once", 512'(clr_cnt), 512'd1);
    @(negedge clk);
    chk("flush_valid", 512'(m_valid), 512'd0);
    m_ready = 1'b1;
    en = 4'b0010;
    enq(1, 4, 1'b0);
    wait_idle("idle_flush", 100);

    // Reset mid-line
    en = 4'b0001;
    base = wr_cnt;
    enq(0, 4, 1'b0);
    wait_wr("rst_reach", base + 2);
    clr_cnt = 0;
    rst = 1'b1;
    en = '0;
    clear_all();
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 512'(m_valid), 512'd0);
    chk("rst_mid_clr", 512'(clr_cnt), 512'd0);
    step(1);
    en = 4'b0001;
    enq(0, 4, 1'b0);
    wait_idle("idle_rst", 100);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      en = N'($urandom);
      force_full = ($urandom_range(0, 9) == 0);
      m_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if (rq_data[i].size() == 0 && $urandom_range(0, 3) == 0)
          enq(i, $urandom_range(1, 9), 1'b0);
      step(1);
    end
    en = '1;
    force_full = 1'b0;
    m_ready = 1'b1;
    wait_idle("idle_random", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
